// File: rtl/delay_gate_array.sv
// Clocked, synthesizable stand-in for a delayed bitwise gate: op(a, b) is driven onto w
// after a runtime delay, using either a transport (history tap) or an inertial (per-lane filter) model.
module delay_gate_array #(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 16,
  parameter int DLY_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             mode,
  input  logic [DLY_W-1:0] delay,
  output logic [WIDTH-1:0] w,
  output logic             w_valid,
  output logic             pulse_drop
);

  // The w register is the final delay stage, so the shift chain needs one entry fewer.
  localparam int               HIST_D = (MAX_DELAY > 1) ? MAX_DELAY - 1 : 1;
  localparam logic [DLY_W-1:0] MAX_D  = DLY_W'(MAX_DELAY);

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  logic [WIDTH-1:0] f;
  logic [DLY_W-1:0] d_eff;
  logic [WIDTH-1:0] hist [HIST_D];
  logic [WIDTH-1:0] tap;
  logic [DLY_W-1:0] cnt     [WIDTH];
  logic [DLY_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_inert;
  logic             drop;
  logic [DLY_W-1:0] fill;
  logic [DLY_W-1:0] fill_nxt;
  logic             mode_q;
  logic [DLY_W-1:0] deff_q;
  logic             chg;

  // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    f = a;
    case (op_e'(op))
      OP_AND:  f = a & b;
      OP_OR:   f = a | b;
      OP_XOR:  f = a ^ b;
      default: f = a;
    endcase
  end

  always_comb begin
    if (delay == '0)       d_eff = DLY_W'(1);
    else if (delay > MAX_D) d_eff = MAX_D;
    else                    d_eff = delay;
  end

  // Tap k holds f from k+1 edges ago relative to the edge that loads w; D_eff = 1 is f itself.
  always_comb begin
    tap = f;
    for (int k = 1; k < MAX_DELAY; k++) begin
      if (d_eff == DLY_W'(k + 1)) tap = hist[k-1];
    end
  end

  assign chg = (mode != mode_q) || (d_eff != deff_q);

  // A mode/delay change clears every lane before threshold is considered, so the clear wins.
  always_comb begin
    cnt_nxt = cnt;
    w_inert = w;
    drop    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (chg || !mode) begin
        cnt_nxt[i] = '0;
      end else if (f[i] == w[i]) begin
        if (cnt[i] != '0) drop = 1'b1;
        cnt_nxt[i] = '0;
      end else if ((cnt[i] + DLY_W'(1)) == d_eff) begin
        w_inert[i] = f[i];
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + DLY_W'(1);
      end
    end
  end

  assign fill_nxt = (fill == MAX_D) ? fill : fill + DLY_W'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      w          <= '0;
      w_valid    <= 1'b0;
      pulse_drop <= 1'b0;
      fill       <= '0;
      mode_q     <= 1'b0;
      deff_q     <= DLY_W'(1);
      // NOTE: the history is cleared on reset because stale taps would otherwise leak onto w after a reset.
      for (int k = 0; k < HIST_D; k++) hist[k] <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      hist[0] <= f;
      for (int k = 1; k < HIST_D; k++) hist[k] <= hist[k-1];
      cnt        <= cnt_nxt;
      w          <= mode ? w_inert : tap;
      pulse_drop <= drop;
      fill       <= fill_nxt;
      w_valid    <= (fill_nxt >= d_eff);
      mode_q     <= mode;
      deff_q     <= d_eff;
    end
  end

endmodule

// File: tb/tb_delay_gate_array.sv
// Scoreboard bench for delay_gate_array: a cycle model pushes expected outputs per edge,
// which are popped and compared one cycle later, plus directed checks on the key scenarios.
module tb_delay_gate_array;

  localparam int WIDTH = 8;
  localparam int MAXD  = 16;
  localparam int DLY_W = 5;
  localparam int LOGN  = 4096;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a, b;
  logic [1:0]       op;
  logic             mode;
  logic [DLY_W-1:0] delay;
  logic [WIDTH-1:0] w;
  logic             w_valid;
  logic             pulse_drop;

  delay_gate_array #(.WIDTH(WIDTH), .MAX_DELAY(MAXD), .DLY_W(DLY_W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .mode(mode), .delay(delay),
    .w(w), .w_valid(w_valid), .pulse_drop(pulse_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] w;
    logic             v;
    logic             pd;
  } exp_t;

  exp_t sbq[$];

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_w;
  int               m_cnt [WIDTH];
  int               m_fill;
  logic             m_v, m_pd;
  logic             m_mode_q;
  int               m_deff_q;
  logic [WIDTH-1:0] flog [LOGN];
  int               t_edge    = 0;
  int               rst_mark  = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] gate(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic [1:0] o);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return x;
    endcase
  endfunction

  // Advance one rising edge: model the edge, queue the expectation, then compare after the edge.
  task automatic tick();
    exp_t             e;
    int               d, j;
    logic [WIDTH-1:0] fv, nw;
    bit               chg;
    logic             pd;
    if (rst) begin
      m_w = '0; m_fill = 0; m_v = 1'b0; m_pd = 1'b0;
      m_mode_q = 1'b0; m_deff_q = 1;
      for (int i = 0; i < WIDTH; i++) m_cnt[i] = 0;
      rst_mark = t_edge;
    end else begin
      fv = gate(a, b, op);
      d  = (delay == 0) ? 1 : ((int'(delay) > MAXD) ? MAXD : int'(delay));
      flog[t_edge % LOGN] = fv;
      chg = (mode != m_mode_q) || (d != m_deff_q);
      pd  = 1'b0;
      nw  = m_w;
      if (!mode) begin
        j  = t_edge - d + 1;
        nw = (j > rst_mark) ? flog[j % LOGN] : '0;
        for (int i = 0; i < WIDTH; i++) m_cnt[i] = 0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (chg) m_cnt[i] = 0;
          else if (fv[i] == m_w[i]) begin
            if (m_cnt[i] != 0) pd = 1'b1;
            m_cnt[i] = 0;
          end else if (m_cnt[i] + 1 == d) begin
            nw[i] = fv[i];
            m_cnt[i] = 0;
          end else m_cnt[i]++;
        end
      end
      m_w      = nw;
      m_fill   = (m_fill < MAXD) ? m_fill + 1 : MAXD;
      m_v      = (m_fill >= d);
      m_pd     = pd;
      m_mode_q = mode;
      m_deff_q = d;
    end
    t_edge++;
    sbq.push_back('{w: m_w, v: m_v, pd: m_pd});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("sb_w", 32'(w), 32'(e.w));
    check("sb_valid", 32'(w_valid), 32'(e.v));
    check("sb_drop", 32'(pulse_drop), 32'(e.pd));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; a = 8'hFF; b = 8'hFF; op = 2'b00; mode = 1'b0; delay = 5'd3;

    // Reset held 3 cycles with a = b = FF.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_w", 32'(w), 32'h00);
      check("rst_valid", 32'(w_valid), 32'h0);
      check("rst_drop", 32'(pulse_drop), 32'h0);
    end
    rst = 1'b0;
    ticks(2);
    check("valid_early", 32'(w_valid), 32'h0);
    tick();
    check("valid_rise", 32'(w_valid), 32'h1);

    // Transport AND with a one-cycle glitch.
    ticks(3);
    a = 8'hF0; b = 8'h3C;
    ticks(2);
    check("and_pre", 32'(w), 32'hFF);
    tick();
    check("and_lat3", 32'(w), 32'h30);
    ticks(6);
    a = 8'hFF;
    tick();
    a = 8'hF0;
    ticks(2);
    check("glitch_on", 32'(w), 32'h3C);
    tick();
    check("glitch_off", 32'(w), 32'h30);

    // Inertial filtering, delay 4, pass-through operator.
    mode = 1'b1; delay = 5'd4; op = 2'b11; a = 8'h00;
    ticks(8);
    check("inert_settle", 32'(w), 32'h00);
    a = 8'h01;
    ticks(2);
    a = 8'h00;
    tick();
    check("short_w", 32'(w), 32'h00);
    check("short_drop", 32'(pulse_drop), 32'h1);
    tick();
    check("short_drop_end", 32'(pulse_drop), 32'h0);
    ticks(2);
    a = 8'h01;
    ticks(3);
    check("long_pre", 32'(w), 32'h00);
    tick();
    check("long_rise", 32'(w), 32'h01);
    a = 8'h00;
    ticks(3);
    check("long_hold", 32'(w), 32'h01);
    tick();
    check("long_fall", 32'(w), 32'h00);

    // Clamping: delay 0 behaves as 1, delay 31 as MAX_DELAY.
    mode = 1'b0; delay = 5'd0; a = 8'h55;
    ticks(3);
    a = 8'hAA;
    tick();
    check("clamp_lo", 32'(w), 32'hAA);
    delay = 5'd31; a = 8'h11;
    ticks(20);
    a = 8'h22;
    ticks(15);
    check("clamp_hi_pre", 32'(w), 32'h11);
    tick();
    check("clamp_hi", 32'(w), 32'h22);
    check("clamp_hi_valid", 32'(w_valid), 32'h1);

    // Delay change mid-stream with saturated fill.
    delay = 5'd2;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      tick();
    end
    delay = 5'd6;
    tick();
    check("chg_valid", 32'(w_valid), 32'h1);
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      tick();
    end

    // Same change right after reset: w_valid waits for fill to reach 6.
    rst = 1'b1;
    tick();
    rst = 1'b0; delay = 5'd2;
    tick();
    delay = 5'd6;
    ticks(4);
    check("fill_wait", 32'(w_valid), 32'h0);
    tick();
    check("fill_done", 32'(w_valid), 32'h1);

    // Mode switch with two cycles pending in every lane.
    mode = 1'b1; delay = 5'd4; op = 2'b11; a = 8'h00;
    ticks(8);
    a = 8'hFF;
    ticks(2);
    mode = 1'b0;
    tick();
    check("sw_drop", 32'(pulse_drop), 32'h0);
    check("sw_tap", 32'(w), 32'h00);
    tick();
    check("sw_tap2", 32'(w), 32'hFF);

    // Reset asserted mid-pulse.
    mode = 1'b1; a = 8'h00;
    ticks(8);
    a = 8'hFF;
    ticks(2);
    rst = 1'b1;
    tick();
    check("mid_rst_w", 32'(w), 32'h00);
    check("mid_rst_valid", 32'(w_valid), 32'h0);
    check("mid_rst_drop", 32'(pulse_drop), 32'h0);
    rst = 1'b0;

    // Random traffic with occasional mode/delay changes and resets.
    for (int i = 0; i < 250; i++) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) op = 2'($urandom);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 15) == 0) delay = 5'($urandom_range(0, 20));
      if (mode && $urandom_range(0, 1) == 0) a = w;  // bias toward short pulses
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
